vc_mem_arb_2to1: RTL and testbench

- Two-requester, round-robin arbiter that shares one single-port test memory (val/rdy memory request/response messages) between port 0 (e.g. instruction fetch) and port 1 (e.g. data access).
- Forwards one request per cycle to the memory.
- Records the winning port ID in an in-order tag queue.
- Steers each memory response back to the port recorded at the queue head.
- Sits between processor-side ports and the memory in processor test harnesses.

---
 rtl/vc_mem_arb_2to1_pkg.sv | 27 ++
 rtl/vc_mem_arb_tag_queue.sv | 71 +++++++
 rtl/vc_mem_arb_2to1.sv | 109 ++++++++++
 tb/tb_vc_mem_arb_2to1.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vc_mem_arb_2to1_pkg.sv
// Shared types and message-size helpers for the 2:1 memory arbiter.
// Request message layout:  {type, addr, len, data}
// Response message layout: {type, len, data}
// The len field is log2(data bytes) wide; len == 0 means a full word.
package vc_mem_arb_2to1_pkg;

    // Width of a tag queue entry: one bit is enough to name one of two ports.
    localparam int c_tag_sz = 1;

    typedef enum logic [c_tag_sz-1:0] {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_e;

    function automatic int mem_len_sz(input int data_sz);
        return $clog2(data_sz / 8);
    endfunction

    function automatic int req_msg_sz(input int addr_sz, input int data_sz);
        return 1 + addr_sz + mem_len_sz(data_sz) + data_sz;
    endfunction

    function automatic int resp_msg_sz(input int data_sz);
        return 1 + mem_len_sz(data_sz) + data_sz;
    endfunction

endpackage

// File: rtl/vc_mem_arb_tag_queue.sv
// In-order queue of port tags for requests that have been forwarded to
// memory and not yet answered. Circular buffer; depth must be a power of 2
// so the pointers wrap naturally. A push is refused whenever the queue is
// full at the start of the cycle, even if a pop happens in the same cycle,
// so enq_rdy never depends on the response path.
module vc_mem_arb_tag_queue
    import vc_mem_arb_2to1_pkg::*;
#(
    parameter int p_depth = 4,
    localparam int c_ptr_sz = (p_depth > 1) ? $clog2(p_depth) : 1,
    localparam int c_cnt_sz = c_ptr_sz + 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enq_val,
    output logic                enq_rdy,
    input  logic [c_tag_sz-1:0] enq_bits,
    output logic                deq_val,
    input  logic                deq_rdy,
    output logic [c_tag_sz-1:0] deq_bits
);

    logic [c_tag_sz-1:0] entries [p_depth];
    logic [c_ptr_sz-1:0] enq_ptr;
    logic [c_ptr_sz-1:0] deq_ptr;
    logic [c_cnt_sz-1:0] count;
    logic                full;
    logic                empty;
    logic                do_enq;
    logic                do_deq;

    // Status flags and handshake qualification.
    always_comb begin
        full     = (count == c_cnt_sz'(p_depth));
        empty    = (count == '0);
        enq_rdy  = !full;
        deq_val  = !empty;
        do_enq   = enq_val && !full;
        do_deq   = deq_rdy && !empty;
        deq_bits = entries[deq_ptr];
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            enq_ptr <= '0;
            deq_ptr <= '0;
            count   <= '0;
        end else begin
            if (do_enq) begin
                enq_ptr <= enq_ptr + c_ptr_sz'(1);
            end
            if (do_deq) begin
                deq_ptr <= deq_ptr + c_ptr_sz'(1);
            end
            case ({do_enq, do_deq})
                2'b10:   count <= count + c_cnt_sz'(1);
                2'b01:   count <= count - c_cnt_sz'(1);
                default: count <= count;
            endcase
        end
    end

    // Tag storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_enq) begin
            entries[enq_ptr] <= enq_bits;
        end
    end

endmodule

// File: rtl/vc_mem_arb_2to1.sv
// Round-robin 2:1 arbiter in front of a single-port test memory.
// Requests pass straight through to memory with no added latency; the
// winning port is remembered in an in-order tag queue and each memory
// response is steered to the port at the queue head. Under continuous
// contention grants strictly alternate, starting with port 0 after reset.
// All val/rdy outputs are held low while reset is asserted.
module vc_mem_arb_2to1
    import vc_mem_arb_2to1_pkg::*;
#(
    parameter int p_addr_sz = 16,
    parameter int p_data_sz = 32,
    parameter int p_max_out = 4,
    localparam int c_req_sz  = req_msg_sz(p_addr_sz, p_data_sz),
    localparam int c_resp_sz = resp_msg_sz(p_data_sz)
) (
    input  logic                 clk,
    input  logic                 reset,

    input  logic                 req0_val,
    output logic                 req0_rdy,
    input  logic [c_req_sz-1:0]  req0_msg,

    input  logic                 req1_val,
    output logic                 req1_rdy,
    input  logic [c_req_sz-1:0]  req1_msg,

    output logic                 resp0_val,
    input  logic                 resp0_rdy,
    output logic [c_resp_sz-1:0] resp0_msg,

    output logic                 resp1_val,
    input  logic                 resp1_rdy,
    output logic [c_resp_sz-1:0] resp1_msg,

    output logic                 memreq_val,
    input  logic                 memreq_rdy,
    output logic [c_req_sz-1:0]  memreq_msg,

    input  logic                 memresp_val,
    output logic                 memresp_rdy,
    input  logic [c_resp_sz-1:0] memresp_msg
);

    port_e               prio;
    port_e               winner;
    port_e               head;
    logic                can_issue;
    logic                req_fire;
    logic                head_rdy;
    logic                tagq_enq_rdy;
    logic                tagq_deq_val;
    logic                tagq_deq_rdy;
    logic [c_tag_sz-1:0] tagq_deq_bits;

    // Pick the winner: a lone requester always wins, otherwise the pointer decides.
    always_comb begin
        winner = prio;
        if (req0_val && !req1_val) begin
            winner = PORT0;
        end else if (req1_val && !req0_val) begin
            winner = PORT1;
        end
    end

    // Request path: forward the winner's message and hand ready only to the winner.
    always_comb begin
        can_issue  = memreq_rdy && tagq_enq_rdy;
        memreq_val = !reset && (req0_val || req1_val) && tagq_enq_rdy;
        memreq_msg = (winner == PORT1) ? req1_msg : req0_msg;
        req0_rdy   = !reset && can_issue && (winner == PORT0);
        req1_rdy   = !reset && can_issue && (winner == PORT1);
        req_fire   = (req0_val && req0_rdy) || (req1_val && req1_rdy);
    end

    // Priority pointer moves to the port that just lost, giving strict alternation.
    always_ff @(posedge clk) begin
        if (reset) begin
            prio <= PORT0;
        end else if (req_fire) begin
            prio <= (winner == PORT0) ? PORT1 : PORT0;
        end
    end

    // Response path: steer memory responses to the port at the head of the tag queue.
    always_comb begin
        head         = port_e'(tagq_deq_bits);
        head_rdy     = (head == PORT1) ? resp1_rdy : resp0_rdy;
        memresp_rdy  = !reset && tagq_deq_val && head_rdy;
        resp0_val    = !reset && memresp_val && tagq_deq_val && (head == PORT0);
        resp1_val    = !reset && memresp_val && tagq_deq_val && (head == PORT1);
        resp0_msg    = memresp_msg;
        resp1_msg    = memresp_msg;
        tagq_deq_rdy = memresp_val && memresp_rdy;
    end

    vc_mem_arb_tag_queue #(
        .p_depth (p_max_out)
    ) u_tagq (
        .clk      (clk),
        .reset    (reset),
        .enq_val  (req_fire),
        .enq_rdy  (tagq_enq_rdy),
        .enq_bits (winner),
        .deq_val  (tagq_deq_val),
        .deq_rdy  (tagq_deq_rdy),
        .deq_bits (tagq_deq_bits)
    );

endmodule

// File: tb/tb_vc_mem_arb_2to1.sv
// Directed bench for vc_mem_arb_2to1 with a byte-addressed memory model
// that answers each accepted request one cycle later, in order.
module tb_vc_mem_arb_2to1;

    localparam int REQ_SZ  = 51;   // 1 + 16 + 2 + 32
    localparam int RESP_SZ = 35;   // 1 + 2 + 32
    localparam logic T_RD  = 1'b0;
    localparam logic T_WR  = 1'b1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic req0_val = 0, req1_val = 0, resp0_rdy = 0, resp1_rdy = 0;
    logic memreq_rdy = 0, memresp_val = 0;
    logic [REQ_SZ-1:0]  req0_msg = '0, req1_msg = '0;
    logic [RESP_SZ-1:0] memresp_msg = '0;
    logic req0_rdy, req1_rdy, resp0_val, resp1_val, memreq_val, memresp_rdy;
    logic [RESP_SZ-1:0] resp0_msg, resp1_msg;
    logic [REQ_SZ-1:0]  memreq_msg;

    int checks = 0;
    int errors = 0;

    logic [REQ_SZ-1:0]  src0[$], src1[$];
    logic [RESP_SZ-1:0] mq[$], r0log[$], r1log[$];
    int                 glog[$];
    logic [7:0]         mem [65536];

    int   d0 = 0, d1 = 0, k0 = 0, k1 = 0;
    int   src_dly = 0, sink_dly = 0;
    logic sink0_en = 1, sink1_en = 1;
    logic saw_resp1 = 0, both_resp = 0, proto_err = 0;
    logic last_memreq_val = 0, last_rdy0 = 0, last_rdy1 = 0;

    vc_mem_arb_2to1 dut (
        .clk(clk), .reset(reset),
        .req0_val(req0_val), .req0_rdy(req0_rdy), .req0_msg(req0_msg),
        .req1_val(req1_val), .req1_rdy(req1_rdy), .req1_msg(req1_msg),
        .resp0_val(resp0_val), .resp0_rdy(resp0_rdy), .resp0_msg(resp0_msg),
        .resp1_val(resp1_val), .resp1_rdy(resp1_rdy), .resp1_msg(resp1_msg),
        .memreq_val(memreq_val), .memreq_rdy(memreq_rdy), .memreq_msg(memreq_msg),
        .memresp_val(memresp_val), .memresp_rdy(memresp_rdy), .memresp_msg(memresp_msg)
    );

    always #5 clk = ~clk;

    function automatic logic [REQ_SZ-1:0] mk_req(logic t, logic [15:0] a, logic [1:0] l, logic [31:0] d);
        return {t, a, l, d};
    endfunction

    function automatic logic [RESP_SZ-1:0] mk_resp(logic t, logic [1:0] l, logic [31:0] d);
        return {t, l, d};
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mem_access(logic [REQ_SZ-1:0] m);
        logic        t;
        logic [15:0] a;
        logic [1:0]  l;
        logic [31:0] d;
        logic [31:0] rd;
        int          nb;
        t  = m[50];
        a  = m[49:34];
        l  = m[33:32];
        d  = m[31:0];
        rd = '0;
        nb = (l == 2'd0) ? 4 : int'(l);
        for (int i = 0; i < nb; i++) begin
            if (t == T_WR) mem[16'(a + 16'(i))] = d[8*i +: 8];
            else           rd[8*i +: 8] = mem[16'(a + 16'(i))];
        end
        mq.push_back({t, l, (t == T_WR) ? 32'h0 : rd});
    endtask

    // One clock cycle: drive at negedge, sample 1ns later, update model after next negedge.
    task automatic cycle();
        logic f_rq0, f_rq1, f_mrq, f_mrs, f_rs0, f_rs1;
        logic [REQ_SZ-1:0]  mrq;
        logic [RESP_SZ-1:0] rs0, rs1;
        req0_val    = (src0.size() != 0) && (d0 == 0);
        req0_msg    = (src0.size() != 0) ? src0[0] : '0;
        req1_val    = (src1.size() != 0) && (d1 == 0);
        req1_msg    = (src1.size() != 0) ? src1[0] : '0;
        resp0_rdy   = sink0_en && (k0 == 0);
        resp1_rdy   = sink1_en && (k1 == 0);
        memreq_rdy  = 1'b1;
        memresp_val = (mq.size() != 0);
        memresp_msg = (mq.size() != 0) ? mq[0] : '0;
        #1;
        f_rq0 = req0_val && req0_rdy;
        f_rq1 = req1_val && req1_rdy;
        f_mrq = memreq_val && memreq_rdy;
        f_mrs = memresp_val && memresp_rdy;
        f_rs0 = resp0_val && resp0_rdy;
        f_rs1 = resp1_val && resp1_rdy;
        mrq   = memreq_msg;
        rs0   = resp0_msg;
        rs1   = resp1_msg;
        if (resp1_val) saw_resp1 = 1'b1;
        if (resp0_val && resp1_val) both_resp = 1'b1;
        if (f_mrq != (f_rq0 || f_rq1)) proto_err = 1'b1;
        if (f_mrs != (f_rs0 || f_rs1)) proto_err = 1'b1;
        last_memreq_val = memreq_val;
        last_rdy0 = req0_rdy;
        last_rdy1 = req1_rdy;
        @(posedge clk);
        @(negedge clk);
        if (d0 > 0) d0--;
        if (d1 > 0) d1--;
        if (k0 > 0) k0--;
        if (k1 > 0) k1--;
        if (f_rq0) begin void'(src0.pop_front()); glog.push_back(0); d0 = $urandom_range(0, src_dly); end
        if (f_rq1) begin void'(src1.pop_front()); glog.push_back(1); d1 = $urandom_range(0, src_dly); end
        if (f_mrs) void'(mq.pop_front());
        if (f_mrq) mem_access(mrq);
        if (f_rs0) begin r0log.push_back(rs0); k0 = $urandom_range(0, sink_dly); end
        if (f_rs1) begin r1log.push_back(rs1); k1 = $urandom_range(0, sink_dly); end
    endtask

    task automatic run(string tag, int n0, int n1, int budget);
        int k;
        k = 0;
        while ((r0log.size() < n0 || r1log.size() < n1) && k < budget) begin
            cycle();
            k++;
        end
        checks++;
        assert (k < budget) else begin
            errors++;
            $error("FAIL %s timeout observed=%0d/%0d expected=%0d/%0d responses",
                   tag, r0log.size(), r1log.size(), n0, n1);
        end
    endtask

    task automatic clear_logs();
        r0log.delete();
        r1log.delete();
        glog.delete();
        saw_resp1 = 0;
        both_resp = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req0_val = 0; req1_val = 0; memresp_val = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        src0.delete(); src1.delete(); mq.delete();
        d0 = 0; d1 = 0; k0 = 0; k1 = 0;
        src_dly = 0; sink_dly = 0;
        clear_logs();
    endtask

    initial begin
        @(negedge clk);
        // Reset in force: every val/rdy output low despite active inputs.
        req0_val = 1; req1_val = 1; resp0_rdy = 1; resp1_rdy = 1;
        memreq_rdy = 1; memresp_val = 1;
        #1;
        chk("reset_outs", {req0_rdy, req1_rdy, memreq_val, memresp_rdy, resp0_val, resp1_val}, 6'b0);
        @(negedge clk);
        do_reset();

        // Port 0 alone: write then read back a word.
        src0.push_back(mk_req(T_WR, 16'h0000, 2'd0, 32'h0a0b0c0d));
        src0.push_back(mk_req(T_RD, 16'h0000, 2'd0, 32'h0));
        run("p0_only", 2, 0, 50);
        chk("p0_wr_resp", r0log[0], mk_resp(T_WR, 2'd0, 32'h0));
        chk("p0_rd_resp", r0log[1], mk_resp(T_RD, 2'd0, 32'h0a0b0c0d));
        chk("p0_no_resp1", saw_resp1, 1'b0);
        chk("p0_grants", {glog.size(), glog[0], glog[1]}, {32'd2, 32'd0, 32'd0});

        // Both ports contending every cycle: grants alternate starting at port 0.
        do_reset();
        src0.push_back(mk_req(T_WR, 16'h0010, 2'd0, 32'h11111111));
        src0.push_back(mk_req(T_RD, 16'h0010, 2'd0, 32'h0));
        src1.push_back(mk_req(T_WR, 16'h0020, 2'd0, 32'h22222222));
        src1.push_back(mk_req(T_RD, 16'h0020, 2'd0, 32'h0));
        run("contend", 2, 2, 50);
        chk("alt_grant_cnt", glog.size(), 4);
        chk("alt_grants", {glog[0][0], glog[1][0], glog[2][0], glog[3][0]}, 4'b0101);
        chk("contend_r0", {r0log[0], r0log[1]},
            {mk_resp(T_WR, 2'd0, 32'h0), mk_resp(T_RD, 2'd0, 32'h11111111)});
        chk("contend_r1", {r1log[0], r1log[1]},
            {mk_resp(T_WR, 2'd0, 32'h0), mk_resp(T_RD, 2'd0, 32'h22222222)});
        chk("contend_steer", {both_resp, proto_err}, 2'b00);

        // Port 1 sink stalled with its tag at the head: at most 4 requests go out.
        clear_logs();
        sink1_en = 0;
        d0 = 1;
        src1.push_back(mk_req(T_RD, 16'h0020, 2'd0, 32'h0));
        src0.push_back(mk_req(T_WR, 16'h0040, 2'd0, 32'h44444444));
        src0.push_back(mk_req(T_WR, 16'h0044, 2'd0, 32'h55555555));
        src0.push_back(mk_req(T_RD, 16'h0040, 2'd0, 32'h0));
        src0.push_back(mk_req(T_RD, 16'h0044, 2'd0, 32'h0));
        src0.push_back(mk_req(T_RD, 16'h0010, 2'd0, 32'h0));
        src0.push_back(mk_req(T_RD, 16'h0020, 2'd0, 32'h0));
        repeat (20) cycle();
        chk("bp_forwarded", glog.size(), 4);
        chk("bp_blocked", {last_memreq_val, last_rdy0, last_rdy1}, 3'b000);
        chk("bp_tag_count", dut.u_tagq.count, 4);
        chk("bp_no_resp", {r0log.size(), r1log.size()}, 64'd0);
        sink1_en = 1;
        run("bp_drain", 6, 1, 100);
        chk("bp_r1", r1log[0], mk_resp(T_RD, 2'd0, 32'h22222222));
        chk("bp_r0_wr", {r0log[0], r0log[1]}, {mk_resp(T_WR, 2'd0, 32'h0), mk_resp(T_WR, 2'd0, 32'h0)});
        chk("bp_r0_rd_a", {r0log[2], r0log[3]},
            {mk_resp(T_RD, 2'd0, 32'h44444444), mk_resp(T_RD, 2'd0, 32'h55555555)});
        chk("bp_r0_rd_b", {r0log[4], r0log[5]},
            {mk_resp(T_RD, 2'd0, 32'h11111111), mk_resp(T_RD, 2'd0, 32'h22222222)});
        chk("bp_drained", dut.u_tagq.count, 0);

        // Sub-word accesses across ports.
        clear_logs();
        src0.push_back(mk_req(T_WR, 16'h0008, 2'd0, 32'h0a0b0c0d));
        run("xp_wr0", 1, 0, 50);
        src1.push_back(mk_req(T_WR, 16'h0008, 2'd1, 32'h000000ef));
        run("xp_wr1", 1, 1, 50);
        src0.push_back(mk_req(T_RD, 16'h0009, 2'd1, 32'h0));
        src0.push_back(mk_req(T_RD, 16'h0008, 2'd1, 32'h0));
        run("xp_rd", 3, 1, 50);
        chk("xp_byte_wr", r1log[0], mk_resp(T_WR, 2'd1, 32'h0));
        chk("xp_rd_09", r0log[1], mk_resp(T_RD, 2'd1, 32'h0000000c));
        chk("xp_rd_08", r0log[2], mk_resp(T_RD, 2'd1, 32'h000000ef));

        // Random source/sink delays, 14 mixed requests per port.
        clear_logs();
        src_dly = 3;
        sink_dly = 10;
        for (int i = 0; i < 7; i++) begin
            src0.push_back(mk_req(T_WR, 16'h0100 + 16'(4*i), 2'd0, 32'ha0000000 + 32'(i)));
            src0.push_back(mk_req(T_RD, 16'h0100 + 16'(4*i), 2'd0, 32'h0));
            src1.push_back(mk_req(T_WR, 16'h0200 + 16'(4*i), 2'd0, 32'hb0000000 + 32'(i)));
            src1.push_back(mk_req(T_RD, 16'h0200 + 16'(4*i), 2'd0, 32'h0));
        end
        run("rand", 14, 14, 500);
        for (int i = 0; i < 7; i++) begin
            chk("rand_r0", {r0log[2*i], r0log[2*i+1]},
                {mk_resp(T_WR, 2'd0, 32'h0), mk_resp(T_RD, 2'd0, 32'ha0000000 + 32'(i))});
            chk("rand_r1", {r1log[2*i], r1log[2*i+1]},
                {mk_resp(T_WR, 2'd0, 32'h0), mk_resp(T_RD, 2'd0, 32'hb0000000 + 32'(i))});
        end
        chk("rand_count", dut.u_tagq.count, 0);
        chk("rand_steer", {both_resp, proto_err}, 2'b00);
        src_dly = 0;
        sink_dly = 0;
        k0 = 0; k1 = 0; d0 = 0; d1 = 0;

        // Reset with three requests outstanding.
        clear_logs();
        sink0_en = 0;
        for (int i = 0; i < 3; i++) src0.push_back(mk_req(T_RD, 16'h0010, 2'd0, 32'h0));
        repeat (6) cycle();
        chk("mid_outstanding", dut.u_tagq.count, 3);
        reset = 1'b1;
        req0_val = 1; req1_val = 1; resp0_rdy = 1; resp1_rdy = 1;
        memreq_rdy = 1; memresp_val = 1;
        #1;
        chk("mid_reset_outs_a", {req0_rdy, req1_rdy, memreq_val, memresp_rdy, resp0_val, resp1_val}, 6'b0);
        @(negedge clk);
        #1;
        chk("mid_reset_outs_b", {req0_rdy, req1_rdy, memreq_val, memresp_rdy, resp0_val, resp1_val}, 6'b0);
        @(negedge clk);
        reset = 1'b0;
        req0_val = 0; req1_val = 0; memresp_val = 0;
        src0.delete(); src1.delete(); mq.delete();
        clear_logs();
        sink0_en = 1;
        #1;
        chk("post_reset_empty", dut.u_tagq.count, 0);
        req0_val = 1; req1_val = 1;
        #1;
        chk("post_reset_prio", {memreq_val, req0_rdy, req1_rdy}, 3'b110);
        memreq_rdy = 0;
        #1;
        chk("memreq_stall", {memreq_val, req0_rdy, req1_rdy}, 3'b100);
        req0_val = 0; req1_val = 0; memreq_rdy = 1;
        @(negedge clk);
        src1.push_back(mk_req(T_RD, 16'h0008, 2'd0, 32'h0));
        run("post_reset_p1", 0, 1, 50);
        chk("post_reset_p1_resp", r1log[0], mk_resp(T_RD, 2'd0, 32'h0a0b0cef));
        chk("post_reset_no_r0", r0log.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
